v60_prefetch_queue: RTL and testbench

- Instruction prefetch stage directly upstream of the external memory interface; acts as that block's CPU-side master on the cpu_req/cpu_ready port.
- Fetches aligned 32-bit words from a sequential fetch PC and buffers them as a byte FIFO.
- Presents a little-endian byte window to the instruction decoder.
- A decoder or branch flush redirects fetch to a new, possibly unaligned, address and discards any stale in-flight data.

---
 rtl/v60_prefetch_queue.sv | 229 ++++++++++++++++++++++
 tb/tb_v60_prefetch_queue.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/v60_prefetch_queue.sv
// v60_prefetch_queue
// Instruction prefetch stage. Fetches aligned 32-bit words from a sequential
// fetch PC through the memory interface (cpu_req/cpu_ready handshake), keeps
// them in a circular byte FIFO, and shows the decoder a little-endian byte
// window starting at the head. A flush redirects fetch to any byte address and
// drops data from a transaction that is still in flight.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             redirect fetch (beats consume and fill in the same cycle)
//   flush_addr        new fetch PC, any alignment
//   consume_bytes     bytes taken from the head this cycle (clamped to q_count)
//   q_data            decoder window, byte 0 = head, bytes past q_count read 0
//   q_count           valid bytes in the FIFO
//   q_pc              address of the head byte
//   mem_req/wr/size   request to the memory interface (read, word size)
//   mem_addr          word-aligned fetch address, held until the data returns
//   mem_rdata/ready   response from the memory interface
//
// Optional build: define V60_PREFETCH_STATS_EN to add the saturating
// stat_fetches / stat_flushes counters.

`ifndef V60_ADDR_WIDTH
`define V60_ADDR_WIDTH 32
`endif

module v60_prefetch_queue #(
    parameter int QUEUE_BYTES  = 16,
    parameter int WINDOW_BYTES = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic [`V60_ADDR_WIDTH-1:0]    flush_addr,
    input  logic [3:0]                    consume_bytes,
    output logic [8*WINDOW_BYTES-1:0]     q_data,
    output logic [$clog2(QUEUE_BYTES):0]  q_count,
    output logic [`V60_ADDR_WIDTH-1:0]    q_pc,
    output logic                          mem_req,
    output logic                          mem_wr,
    output logic [1:0]                    mem_size,
    output logic [`V60_ADDR_WIDTH-1:0]    mem_addr,
    input  logic [31:0]                   mem_rdata,
    input  logic                          mem_ready
`ifdef V60_PREFETCH_STATS_EN
    ,
    output logic [15:0]                   stat_fetches,
    output logic [15:0]                   stat_flushes
`endif
);

    localparam int AW = `V60_ADDR_WIDTH;
    localparam int PW = $clog2(QUEUE_BYTES);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {F_IDLE, F_REQ, F_BUSY} fstate_e;

    fstate_e         state_q, state_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [AW-1:0]   fetch_pc_q, fetch_pc_d;
    logic [AW-1:0]   q_pc_q, q_pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic            discard_q, discard_d;
    logic            seen_busy_q, seen_busy_d;
    logic [7:0]      fifo_q [QUEUE_BYTES];
    logic [7:0]      fifo_d [QUEUE_BYTES];

    logic            capture;
    logic [CW-1:0]   eff;
    logic [1:0]      skip;
    logic [2:0]      n_app;

    // Fetch FSM. In F_BUSY mem_ready was high on entry (the accepting edge),
    // so the data edge is the first high after at least one low cycle.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_d     = state_q;
        mem_addr_d  = mem_addr_q;
        seen_busy_d = seen_busy_q;
        capture     = 1'b0;
        case (state_q)
            F_IDLE: begin
                if (!flush && (32'(count_q) + 32'd4 <= 32'(QUEUE_BYTES))) begin
                    mem_addr_d = {fetch_pc_q[AW-1:2], 2'b00};
                    state_d    = F_REQ;
                end
            end
            F_REQ: begin
                if (mem_ready) begin
                    seen_busy_d = 1'b0;
                    state_d     = F_BUSY;
                end
            end
            F_BUSY: begin
                if (seen_busy_q && mem_ready) begin
                    capture = 1'b1;
                    state_d = F_IDLE;
                end else if (!mem_ready) begin
                    seen_busy_d = 1'b1;
                end
            end
            default: state_d = F_IDLE;
        endcase
    end

    assign mem_req  = (state_q == F_REQ);
    assign mem_wr   = 1'b0;
    assign mem_size = 2'b10;
    assign mem_addr = mem_addr_q;

    // FIFO bookkeeping: consume from the head, append the captured word at the
    // tail. Consume never moves the tail, so appended bytes land after the
    // bytes that remain.
    always_comb begin
        eff   = (32'(consume_bytes) > 32'(count_q)) ? count_q : CW'(consume_bytes);
        skip  = fetch_pc_q[1:0];
        n_app = 3'd4 - {1'b0, skip};

        fifo_d     = fifo_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        q_pc_d     = q_pc_q;
        fetch_pc_d = fetch_pc_q;
        discard_d  = discard_q;

        if (flush) begin
            count_d    = '0;
            head_d     = '0;
            tail_d     = '0;
            q_pc_d     = flush_addr;
            fetch_pc_d = flush_addr;
            // A flush on the capture edge already drops that word, so there is
            // nothing left in flight to discard.
            discard_d  = (state_q != F_IDLE) && !capture;
        end else begin
            head_d  = head_q + PW'(eff);
            q_pc_d  = q_pc_q + AW'(eff);
            count_d = count_q - eff;
            if (capture) begin
                discard_d = 1'b0;
                if (!discard_q) begin
                    for (int k = 0; k < 4; k++) begin
                        if (k >= int'(skip))
                            fifo_d[tail_q + PW'(k - int'(skip))] = mem_rdata[8*k +: 8];
                    end
                    tail_d     = tail_q + PW'(n_app);
                    count_d    = count_q - eff + CW'(n_app);
                    fetch_pc_d = {fetch_pc_q[AW-1:2] + (AW-2)'(1), 2'b00};
                end
            end
        end
    end

    always_comb begin
        q_data = '0;
        for (int i = 0; i < WINDOW_BYTES; i++) begin
            if (CW'(i) < count_q)
                q_data[8*i +: 8] = fifo_q[head_q + PW'(i)];
        end
    end

    assign q_count = count_q;
    assign q_pc    = q_pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            state_q     <= F_IDLE;
            mem_addr_q  <= '0;
            fetch_pc_q  <= '0;
            q_pc_q      <= '0;
            count_q     <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            discard_q   <= 1'b0;
            seen_busy_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_addr_q  <= mem_addr_d;
            fetch_pc_q  <= fetch_pc_d;
            q_pc_q      <= q_pc_d;
            count_q     <= count_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            discard_q   <= discard_d;
            seen_busy_q <= seen_busy_d;
        end
    end

    // NOTE: the byte storage has no reset; q_data masks every byte at or past
    // q_count, so stale contents are never visible.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

`ifdef V60_PREFETCH_STATS_EN
    logic [15:0] stat_fetches_q, stat_fetches_d;
    logic [15:0] stat_flushes_q, stat_flushes_d;

    // Discarded words still count as fetches: they used a memory access.
    always_comb begin
        stat_fetches_d = stat_fetches_q;
        stat_flushes_d = stat_flushes_q;
        if (capture && stat_fetches_q != 16'hFFFF) stat_fetches_d = stat_fetches_q + 16'd1;
        if (flush && stat_flushes_q != 16'hFFFF)   stat_flushes_d = stat_flushes_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetches_q <= '0;
            stat_flushes_q <= '0;
        end else begin
            stat_fetches_q <= stat_fetches_d;
            stat_flushes_q <= stat_flushes_d;
        end
    end

    assign stat_fetches = stat_fetches_q;
    assign stat_flushes = stat_flushes_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_v60_prefetch_queue.sv
// Testbench for v60_prefetch_queue: a word memory responder with adjustable
// wait states, a byte-queue reference model, directed corner cases, a table of
// consume/flush vectors and a randomized run.

`ifndef V60_ADDR_WIDTH
`define V60_ADDR_WIDTH 32
`endif

module tb_v60_prefetch_queue;

    localparam int QB = 16;
    localparam int WB = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [31:0] flush_addr;
    logic [3:0]  consume_bytes;
    logic [63:0] q_data;
    logic [4:0]  q_count;
    logic [31:0] q_pc;
    logic        mem_req, mem_wr, mem_ready;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr, mem_rdata;
`ifdef V60_PREFETCH_STATS_EN
    logic [15:0] stat_fetches, stat_flushes;
`endif

    v60_prefetch_queue #(.QUEUE_BYTES(QB), .WINDOW_BYTES(WB)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .flush_addr(flush_addr),
        .consume_bytes(consume_bytes), .q_data(q_data), .q_count(q_count),
        .q_pc(q_pc), .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
`ifdef V60_PREFETCH_STATS_EN
        , .stat_fetches(stat_fetches), .stat_flushes(stat_flushes)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word_at(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'h4433_2211;
            32'h0000_1004: return 32'h8877_6655;
            32'h0000_2000: return 32'hDDCC_BBAA;
            default:       return (a ^ 32'hA5A5_5A5A) * 32'h9E37_79B1 + 32'h1234_5677;
        endcase
    endfunction

    // Memory responder: accepts at an edge with mem_req && mem_ready, then
    // holds mem_ready low for wait_cycles cycles before returning the word.
    bit          resp_en      = 1'b1;
    bit          resp_busy    = 1'b0;
    bit          resp_deliver = 1'b0;
    int          wait_cycles  = 1;
    logic [31:0] acc_addr     = '0;
    logic [31:0] acc_log[$];

    initial begin
        logic        rq, rd;
        logic [31:0] ad;
        int          left;
        mem_ready = 1'b0;
        mem_rdata = '0;
        left      = 0;
        forever begin
            @(negedge clk);
            rq = mem_req; rd = mem_ready; ad = mem_addr;
            @(posedge clk);
            #1;
            if (resp_deliver) begin
                resp_deliver = 1'b0;
                resp_busy    = 1'b0;
                mem_ready    = resp_en;
            end else if (rq && rd) begin
                resp_busy = 1'b1;
                mem_ready = 1'b0;
                acc_addr  = ad;
                acc_log.push_back(ad);
                left      = wait_cycles;
            end else if (resp_busy) begin
                if (left > 1) left--;
                else begin
                    mem_ready    = 1'b1;
                    mem_rdata    = word_at(acc_addr);
                    resp_deliver = 1'b1;
                end
            end else begin
                mem_ready = resp_en;
            end
        end
    end

    // Reference model: the FIFO as a byte queue plus the architectural PCs.
    byte unsigned mq[$];
    logic [31:0]  m_pc, m_fpc;
    bit           m_disc;
    int           m_caps, m_flushes;

    function automatic logic [63:0] window();
        logic [63:0] w = '0;
        for (int i = 0; i < WB; i++)
            if (i < mq.size()) w[8*i +: 8] = mq[i];
        return w;
    endfunction

    // One clock: drive inputs at the negedge, update the model at the edge,
    // compare at the following negedge.
    task automatic step(input bit f, input logic [31:0] fa, input logic [3:0] cb);
        bit          cap, infl;
        logic [31:0] wd;
        int          eff, skip;
        flush = f; flush_addr = fa; consume_bytes = cb;
        cap  = resp_deliver;
        infl = mem_req || resp_busy;
        if (resp_busy) begin
            check("addr_stable", mem_addr, acc_addr);
            check("one_outstanding", mem_req, 0);
        end
        if (cap && !m_disc) check("fetch_addr", mem_addr, {m_fpc[31:2], 2'b00});
        @(posedge clk);
        if (cap) m_caps++;
        if (f) begin
            m_flushes++;
            mq.delete();
            m_pc   = fa;
            m_fpc  = fa;
            m_disc = infl && !cap;
        end else begin
            eff = (int'(cb) > mq.size()) ? mq.size() : int'(cb);
            repeat (eff) void'(mq.pop_front());
            m_pc += eff;
            if (cap) begin
                if (!m_disc) begin
                    wd   = word_at({m_fpc[31:2], 2'b00});
                    skip = int'(m_fpc[1:0]);
                    for (int k = skip; k < 4; k++) mq.push_back(wd[8*k +: 8]);
                    check("capacity", mq.size() <= QB, 1);
                    m_fpc = {m_fpc[31:2], 2'b00} + 32'd4;
                end
                m_disc = 1'b0;
            end
        end
        @(negedge clk);
        check("q_count", q_count, mq.size());
        check("q_pc", q_pc, m_pc);
        check("q_data", q_data, window());
        check("mem_const", {mem_wr, mem_size}, 3'b010);
    endtask

    task automatic run_until_count(input int target, input int budget);
        int n = 0;
        while (q_count != target && n < budget) begin
            step(1'b0, '0, 4'd0);
            n++;
        end
        check("reach_count", q_count, target);
    endtask

    typedef struct {
        bit          f;
        logic [31:0] a;
        logic [3:0]  c;
        int          cnt;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int n;
        bit req_seen;

        tbl[0] = '{1'b0, 32'h0, 4'd0, 16, 32'h0000_5000};
        tbl[1] = '{1'b0, 32'h0, 4'd3, 13, 32'h0000_5003};
        tbl[2] = '{1'b0, 32'h0, 4'd8, 5,  32'h0000_500B};
        tbl[3] = '{1'b0, 32'h0, 4'd7, 0,  32'h0000_5010};
        tbl[4] = '{1'b0, 32'h0, 4'd5, 0,  32'h0000_5010};
        tbl[5] = '{1'b1, 32'hFFFF_FFFE, 4'd2, 0, 32'hFFFF_FFFE};
        tbl[6] = '{1'b0, 32'h0, 4'd1, 0,  32'hFFFF_FFFE};

        m_pc = '0; m_fpc = '0; m_disc = 1'b0; m_caps = 0; m_flushes = 0;
        flush = 1'b1; flush_addr = 32'h1000; consume_bytes = '0; rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_q_count", q_count, 0);
        check("rst_q_pc", q_pc, 0);
        check("rst_q_data", q_data, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;

        // Fill from 0x1000 until the FIFO is full.
        step(1'b1, 32'h1000, 4'd0);
        run_until_count(16, 200);
        check("t1_fetch_count", acc_log.size(), 4);
        if (acc_log.size() >= 2) begin
            check("t1_addr0", acc_log[0], 32'h1000);
            check("t1_addr1", acc_log[1], 32'h1004);
        end
        check("t1_window", q_data, 64'h8877_6655_4433_2211);
        req_seen = 1'b0;
        repeat (10) begin
            step(1'b0, '0, 4'd0);
            req_seen |= mem_req;
        end
        check("t1_full_no_req", req_seen, 0);

        // Unaligned redirect: only the top byte of the word is kept.
        step(1'b1, 32'h2003, 4'd0);
        run_until_count(1, 50);
        check("t2_pc", q_pc, 32'h2003);
        check("t2_byte", q_data[7:0], 8'hDD);
        n = 0;
        while (!mem_req && n < 50) begin step(1'b0, '0, 4'd0); n++; end
        check("t2_next_addr", mem_addr, 32'h2004);

        // Flush while the fetch of 0x1008 waits for data.
        wait_cycles = 3;
        step(1'b1, 32'h1008, 4'd0);
        n = 0;
        while (!(resp_busy && acc_addr == 32'h1008) && n < 50) begin step(1'b0, '0, 4'd0); n++; end
        check("t3_inflight", acc_addr, 32'h1008);
        step(1'b1, 32'h3000, 4'd0);
        n = 0;
        while (!mem_req && n < 50) begin step(1'b0, '0, 4'd0); n++; end
        check("t3_redirect_addr", mem_addr, 32'h3000);
        check("t3_dropped", q_count, 0);

        // Over-consume on the same edge as a 4-byte fill.
        wait_cycles = 1;
        step(1'b1, 32'h4002, 4'd0);
        run_until_count(6, 50);
        n = 0;
        while (!resp_deliver && n < 50) begin step(1'b0, '0, 4'd0); n++; end
        check("t4_pre_count", q_count, 6);
        step(1'b0, '0, 4'd8);
        check("t4_count", q_count, 4);
        check("t4_pc", q_pc, 32'h4008);

        // Three wait states per access with the decoder draining slowly.
        wait_cycles = 3;
        step(1'b1, 32'h6000, 4'd0);
        repeat (60) step(1'b0, '0, 4'($urandom_range(0, 4)));

        // Table vectors with the memory stalled, then wrap at the top of memory.
        wait_cycles = 1;
        step(1'b1, 32'h5000, 4'd0);
        run_until_count(16, 100);
        resp_en = 1'b0;
        step(1'b0, '0, 4'd0);
        foreach (tbl[i]) begin
            step(tbl[i].f, tbl[i].a, tbl[i].c);
            check("tbl_count", q_count, tbl[i].cnt);
            check("tbl_pc", q_pc, tbl[i].pc);
        end
        resp_en = 1'b1;
        run_until_count(6, 100);
        check("wrap_pc_hold", q_pc, 32'hFFFF_FFFE);
        step(1'b0, '0, 4'd2);
        check("wrap_pc", q_pc, 32'h0000_0000);

        // Randomized run against the model.
        for (int c = 0; c < 1500; c++) begin
            if ((c % 50) == 0) wait_cycles = $urandom_range(1, 4);
            step($urandom_range(0, 99) < 3, $urandom, 4'($urandom_range(0, WB)));
        end
        repeat (4) step(1'b0, '0, 4'd0);

`ifdef V60_PREFETCH_STATS_EN
        check("stat_fetches", stat_fetches, m_caps);
        check("stat_flushes", stat_flushes, m_flushes);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
